term_reg_bank: RTL and testbench

// - Parametrised multi-channel successor to the 16-bit term register: NUM_CH signed fixed-point term registers.
// - Every channel initialises to fixed-point 1.0; channels are written through one write port and read through one registered read port.
// - Per-channel iteration counting and convergence detection (|term| <= EPS for CONV_CNT consecutive loads) let series-evaluation control stop iterating.

---
 rtl/term_reg_bank_if.sv | 18 +
 rtl/term_reg_bank.sv | 126 ++++++++++++
 tb/tb_term_reg_bank.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/term_reg_bank_if.sv
// Write/read bus of the term register bank.
// master drives the write command and read index; slave returns the registered
// read data and the one-cycle write-error pulse.
// Parameters: WIDTH term width, CH_W channel index width ($clog2 of channel count).
interface term_reg_bank_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CH_W  = 2
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_data;
  logic [CH_W-1:0]  rd_ch;
  logic [WIDTH-1:0] rd_data;
  logic             wr_err;

  modport master (output wr_en, wr_ch, wr_data, rd_ch, input rd_data, wr_err);
  modport slave  (input wr_en, wr_ch, wr_data, rd_ch, output rd_data, wr_err);
endinterface

// File: rtl/term_reg_bank.sv
// Multi-channel signed fixed-point term register bank with per-channel load
// counting and convergence detection for series-evaluation control.
// Ports:
//   clk, custom_reset  clock and synchronous active-high reset
//   ch_init            per-channel re-init to 1.0 (beats a same-cycle write)
//   bus (slave)        wr_en/wr_ch/wr_data write port, rd_ch read index,
//                      rd_data registered read (1-cycle, pre-update), wr_err pulse
//   terms_flat         all terms, channel i at [i*WIDTH +: WIDTH]
//   iter_cnt           saturating load count, channel i at [i*ITER_W +: ITER_W]
//   converged          sticky per-channel convergence flags
// The bus instance must use CH_W = $clog2(NUM_CH).
// Optional macro TERM_BANK_LOCK_EN: writes to a converged channel are rejected
// with a wr_err pulse until ch_init or custom_reset clears the channel.
module term_reg_bank #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC_BITS = 11,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned EPS       = 1,
  parameter int unsigned CONV_CNT  = 2,
  parameter int unsigned ITER_W    = 6
) (
  input  logic                     clk,
  input  logic                     custom_reset,
  input  logic [NUM_CH-1:0]        ch_init,
  term_reg_bank_if.slave           bus,
  output logic [NUM_CH*WIDTH-1:0]  terms_flat,
  output logic [NUM_CH*ITER_W-1:0] iter_cnt,
  output logic [NUM_CH-1:0]        converged
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned RUN_W = $clog2(CONV_CNT + 1);
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1) << FRAC_BITS;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]  term_q [NUM_CH];
  logic [WIDTH-1:0]  term_d [NUM_CH];
  logic [ITER_W-1:0] iter_q [NUM_CH];
  logic [ITER_W-1:0] iter_d [NUM_CH];
  logic [RUN_W-1:0]  run_q  [NUM_CH];
  logic [RUN_W-1:0]  run_d  [NUM_CH];
  logic [NUM_CH-1:0] conv_q, conv_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              wr_err_q, wr_err_d;

  logic [WIDTH-1:0]  wr_mag;
  logic              wr_small;

  // Magnitude of the incoming term; the most-negative code is never small.
  always_comb begin
    wr_mag   = bus.wr_data[WIDTH-1] ? (WIDTH'(0) - bus.wr_data) : bus.wr_data;
    wr_small = (bus.wr_data != MIN_VAL) && (32'(wr_mag) <= EPS);
  end

  // Next-state for all channels, read port and error pulse.
  always_comb begin
    term_d    = term_q;
    iter_d    = iter_q;
    run_d     = run_q;
    conv_d    = conv_q;
    rd_data_d = '0;
    wr_err_d  = bus.wr_en && (32'(bus.wr_ch) >= NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      // Unmatched (out-of-range) read index leaves rd_data_d at zero.
      if (bus.rd_ch == CH_W'(c)) rd_data_d = term_q[c];
      if (ch_init[c]) begin
        term_d[c] = ONE_VAL;
        iter_d[c] = '0;
        run_d[c]  = '0;
        conv_d[c] = 1'b0;
      end else if (bus.wr_en && (bus.wr_ch == CH_W'(c))) begin
`ifdef TERM_BANK_LOCK_EN
        if (conv_q[c]) wr_err_d = 1'b1;
        else
`endif
        begin
          term_d[c] = bus.wr_data;
          if (iter_q[c] != '1) iter_d[c] = iter_q[c] + ITER_W'(1);
          if (wr_small) begin
            if (32'(run_q[c]) < CONV_CNT) run_d[c] = run_q[c] + RUN_W'(1);
            // New run reaches CONV_CNT (saturated run stays there).
            if (32'(run_q[c]) + 1 >= CONV_CNT) conv_d[c] = 1'b1;
          end else begin
            run_d[c] = '0;
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (custom_reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        term_q[c] <= ONE_VAL;
        iter_q[c] <= '0;
        run_q[c]  <= '0;
      end
      conv_q    <= '0;
      rd_data_q <= ONE_VAL;
      wr_err_q  <= 1'b0;
    end else begin
      term_q    <= term_d;
      iter_q    <= iter_d;
      run_q     <= run_d;
      conv_q    <= conv_d;
      rd_data_q <= rd_data_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Flatten register state onto the output vectors.
  always_comb begin
    terms_flat = '0;
    iter_cnt   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      terms_flat[c*WIDTH +: WIDTH]   = term_q[c];
      iter_cnt[c*ITER_W +: ITER_W]   = iter_q[c];
    end
  end

  assign converged   = conv_q;
  assign bus.rd_data = rd_data_q;
  assign bus.wr_err  = wr_err_q;

endmodule

// File: tb/tb_term_reg_bank.sv
// Randomised + directed bench for term_reg_bank against a behavioural model.
module tb_term_reg_bank;
  localparam int unsigned W   = 16;
  localparam int unsigned NCH = 5;
  localparam int unsigned CW  = 3;
  localparam int unsigned IW  = 6;
  localparam int unsigned CC  = 2;
  localparam int          EPSM = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NCH-1:0]    ch_init;
  logic [NCH*W-1:0]  terms_flat;
  logic [NCH*IW-1:0] iter_cnt;
  logic [NCH-1:0]    converged;
  term_reg_bank_if #(.WIDTH(W), .CH_W(CW)) bus ();

  term_reg_bank #(.WIDTH(W), .FRAC_BITS(11), .NUM_CH(NCH), .EPS(EPSM),
                  .CONV_CNT(CC), .ITER_W(IW)) dut (
    .clk(clk), .custom_reset(rst), .ch_init(ch_init), .bus(bus.slave),
    .terms_flat(terms_flat), .iter_cnt(iter_cnt), .converged(converged));

  // Second instance: huge EPS to exercise the most-negative boundary.
  logic [1:0]    ch_init2;
  logic [2*W-1:0] terms2;
  logic [2*IW-1:0] iter2;
  logic [1:0]    conv2;
  term_reg_bank_if #(.WIDTH(W), .CH_W(1)) bus2 ();

  term_reg_bank #(.WIDTH(W), .FRAC_BITS(11), .NUM_CH(2), .EPS(32767),
                  .CONV_CNT(2), .ITER_W(IW)) dut2 (
    .clk(clk), .custom_reset(rst), .ch_init(ch_init2), .bus(bus2.slave),
    .terms_flat(terms2), .iter_cnt(iter2), .converged(conv2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: plain integers per channel.
  int m_term [NCH];
  int m_iter [NCH];
  int m_run  [NCH];
  bit m_conv [NCH];
  int m_rd;
  bit m_err;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int wc, rc, sv, mag;
    bit lock;
    wc = int'(bus.wr_ch);
    rc = int'(bus.rd_ch);
    sv = int'($signed(bus.wr_data));
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_term[c] = 'h0800; m_iter[c] = 0; m_run[c] = 0; m_conv[c] = 0;
      end
      m_rd = 'h0800; m_err = 0; m_valid = 1'b1;
    end else begin
      m_rd  = (rc < NCH) ? m_term[rc] : 0;
      m_err = 0;
      if (bus.wr_en) begin
        if (wc >= NCH) m_err = 1;
        else if (!ch_init[wc]) begin
          lock = 0;
`ifdef TERM_BANK_LOCK_EN
          lock = m_conv[wc];
`endif
          if (lock) m_err = 1;
          else begin
            m_term[wc] = int'(bus.wr_data);
            m_iter[wc] = (m_iter[wc] + 1 > 63) ? 63 : m_iter[wc] + 1;
            mag = (sv < 0) ? -sv : sv;
            if (sv != -32768 && mag <= EPSM) begin
              m_run[wc] = (m_run[wc] + 1 > CC) ? CC : m_run[wc] + 1;
              if (m_run[wc] == CC) m_conv[wc] = 1;
            end else m_run[wc] = 0;
          end
        end
      end
      for (int c = 0; c < NCH; c++)
        if (ch_init[c]) begin
          m_term[c] = 'h0800; m_iter[c] = 0; m_run[c] = 0; m_conv[c] = 0;
        end
    end
    #2;
    if (m_valid) begin
      chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
      chk("wr_err", 32'(bus.wr_err), 32'(m_err));
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("term[%0d]", c), 32'(terms_flat[c*W +: W]), 32'(m_term[c]));
        chk($sformatf("iter[%0d]", c), 32'(iter_cnt[c*IW +: IW]), 32'(m_iter[c]));
        chk($sformatf("conv[%0d]", c), 32'(converged[c]), 32'(m_conv[c]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wr(input int ch, input logic [W-1:0] d);
    bus.wr_en = 1'b1; bus.wr_ch = CW'(ch); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wr2(input logic [W-1:0] d);
    bus2.wr_en = 1'b1; bus2.wr_ch = 1'b0; bus2.wr_data = d;
    tick();
    bus2.wr_en = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] term(input int c);
    return terms_flat[c*W +: W];
  endfunction

  initial begin
    int r;
    rst = 1'b1; ch_init = '0; ch_init2 = '0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.rd_ch = '0;
    bus2.wr_en = 1'b0; bus2.wr_ch = '0; bus2.wr_data = '0; bus2.rd_ch = '0;
    tick();
    rst = 1'b0;

    // Reset values.
    chk("lit_rst_rd", 32'(bus.rd_data), 32'h0800);
    chk("lit_rst_t4", 32'(term(4)), 32'h0800);
    chk("lit_rst_iter", 32'(iter_cnt), 32'h0);
    chk("lit_rst_conv", 32'(converged), 32'h0);

    // Three loads to ch1; convergence on the third.
    wr(1, 16'h0400);
    wr(1, 16'h0001);
    chk("lit_ch1_conv_early", 32'(converged[1]), 32'h0);
    wr(1, 16'h0000);
    chk("lit_ch1_iter", 32'(iter_cnt[1*IW +: IW]), 32'd3);
    chk("lit_ch1_conv", 32'(converged[1]), 32'h1);
    chk("lit_ch0_term", 32'(term(0)), 32'h0800);

    // Large load breaks the run; then -1 completes a new run.
    do_rst();
    wr(2, 16'h0001); wr(2, 16'h0005); wr(2, 16'h0001);
    chk("lit_ch2_noconv", 32'(converged[2]), 32'h0);
    wr(2, 16'hFFFF);
    chk("lit_ch2_conv", 32'(converged[2]), 32'h1);

    // ch_init wins over a same-cycle write, silently.
    wr(3, 16'h0100);
    ch_init = 5'b01000;
    wr(3, 16'h1234);
    ch_init = '0;
    chk("lit_init_term", 32'(term(3)), 32'h0800);
    chk("lit_init_iter", 32'(iter_cnt[3*IW +: IW]), 32'h0);
    chk("lit_init_err", 32'(bus.wr_err), 32'h0);

    // Same-cycle write and read return the old value first.
    bus.rd_ch = 3'd0;
    wr(0, 16'h0200);
    chk("lit_rdw_old", 32'(bus.rd_data), 32'h0800);
    tick();
    chk("lit_rdw_new", 32'(bus.rd_data), 32'h0200);

    // Out-of-range write and read.
    bus.rd_ch = 3'd7;
    wr(6, 16'h5555);
    chk("lit_oor_err", 32'(bus.wr_err), 32'h1);
    chk("lit_oor_rd", 32'(bus.rd_data), 32'h0);
    tick();
    chk("lit_oor_err_clr", 32'(bus.wr_err), 32'h0);

    // Write to converged ch2.
    wr(2, 16'h7777);
`ifdef TERM_BANK_LOCK_EN
    chk("lit_lock_err", 32'(bus.wr_err), 32'h1);
    chk("lit_lock_term", 32'(term(2)), 32'hFFFF);
`else
    chk("lit_nolock_err", 32'(bus.wr_err), 32'h0);
    chk("lit_nolock_term", 32'(term(2)), 32'h7777);
`endif
    chk("lit_conv_sticky", 32'(converged[2]), 32'h1);

    // Iteration counter saturation.
    for (int i = 0; i < 70; i++) wr(4, 16'h0100);
    chk("lit_iter_sat", 32'(iter_cnt[4*IW +: IW]), 32'd63);

    // Most-negative value is never small, even with EPS = 32767.
    wr2(16'h8000); wr2(16'h8000);
    chk("lit_minneg_conv", 32'(conv2[0]), 32'h0);
    chk("lit_minneg_term", 32'(terms2[0 +: W]), 32'h8000);
    wr2(16'h7FFF); wr2(16'h7FFF);
    chk("lit_maxpos_conv", 32'(conv2[0]), 32'h1);
    chk("lit_ch1_untouched", 32'(terms2[W +: W]), 32'h0800);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NCH; c++) ch_init[c] = ($urandom_range(0, 19) == 0);
      bus.wr_en = ($urandom_range(0, 9) < 6);
      bus.wr_ch = CW'($urandom_range(0, 7));
      bus.rd_ch = CW'($urandom_range(0, 7));
      r = $urandom_range(0, 3);
      case (r)
        0: bus.wr_data = W'($urandom_range(0, 4) - 2);
        1: bus.wr_data = 16'h8000;
        default: bus.wr_data = W'($urandom);
      endcase
      tick();
    end
    rst = 1'b0; ch_init = '0; bus.wr_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
